// File: rtl/zion_riscv_isa_lib_slt_de_stage.sv
// Decode stage for the SLT / branch-compare execution path.
// Decodes SLT/SLTI/SLTU/SLTIU and BLT/BGE/BLTU/BGEU, then holds the
// operands in a one-entry valid/ready pipeline register toward EX.
module zion_riscv_isa_lib_slt_de_stage #(
  parameter int RV64 = 0,
  localparam int CPU_WIDTH = (RV64 != 0) ? 64 : 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [31:0]          iInstr,
  input  logic [CPU_WIDTH-1:0] iRs1Data,
  input  logic [CPU_WIDTH-1:0] iRs2Data,
  input  logic                 iFlush,
  output logic                 oValid,
  input  logic                 iReady,
  output logic                 oEn,
  output logic                 oUnsignedFlg,
  output logic [CPU_WIDTH-1:0] oS1,
  output logic [CPU_WIDTH-1:0] oS2,
  output logic                 oIsBranch,
  output logic                 oBrInvert,
  output logic [4:0]           oRd
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = iInstr[6:0];
  assign f3  = iInstr[14:12];
  assign f7  = iInstr[31:25];

  // Register-index fields are not needed: operands arrive already read.
  logic unused_rs_idx;
  assign unused_rs_idx = ^iInstr[24:15];

  logic                 is_imm;
  logic                 is_reg;
  logic                 is_br;
  logic                 de_en;
  logic                 de_uns;
  logic                 de_inv;
  logic [4:0]           de_rd;
  logic [CPU_WIDTH-1:0] de_s1;
  logic [CPU_WIDTH-1:0] de_s2;
  logic [CPU_WIDTH-1:0] imm_sext;

  assign imm_sext = {{(CPU_WIDTH-12){iInstr[31]}}, iInstr[31:20]};

  // Decode; every field is masked to zero for non-matching instructions.
  always_comb begin
    is_imm = (opc == OPC_OP_IMM) && (f3[2:1] == 2'b01);
    is_reg = (opc == OPC_OP) && (f7 == 7'b0000000) && (f3[2:1] == 2'b01);
    is_br  = (opc == OPC_BRANCH) && f3[2];
    de_en  = is_imm | is_reg | is_br;
    // f3[0] selects the unsigned SLT variant; f3[1] selects unsigned branches.
    de_uns = ((is_imm | is_reg) & f3[0]) | (is_br & f3[1]);
    de_inv = is_br & f3[0];
    de_rd  = (is_imm | is_reg) ? iInstr[11:7] : 5'd0;
    de_s1  = de_en ? iRs1Data : '0;
    de_s2  = '0;
    if (is_imm)
      de_s2 = imm_sext;
    else if (is_reg | is_br)
      de_s2 = iRs2Data;
  end

  logic load;
  assign oReady = ~oValid | iReady;
  assign load   = iValid & oReady;

  // One-entry pipeline register: reset > flush > load > drain > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      oValid       <= 1'b0;
      oEn          <= 1'b0;
      oUnsignedFlg <= 1'b0;
      oS1          <= '0;
      oS2          <= '0;
      oIsBranch    <= 1'b0;
      oBrInvert    <= 1'b0;
      oRd          <= 5'd0;
    end else if (iFlush) begin
      oValid <= 1'b0;
    end else if (load) begin
      oValid       <= 1'b1;
      oEn          <= de_en;
      oUnsignedFlg <= de_uns;
      oS1          <= de_s1;
      oS2          <= de_s2;
      oIsBranch    <= is_br;
      oBrInvert    <= de_inv;
      oRd          <= de_rd;
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

endmodule
